// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants, axis state encoding and band helper for the VGA
// sequencer.
package vga_pkg;

    localparam int unsigned CoordW     = 10;
    localparam int unsigned ClkDiv     = 2;

    localparam int unsigned HVisible   = 640;
    localparam int unsigned HFront     = 16;
    localparam int unsigned HSync      = 96;
    localparam int unsigned HBack      = 48;
    localparam int unsigned HTotal     = HVisible + HFront + HSync + HBack;

    localparam int unsigned VVisible   = 480;
    localparam int unsigned VFront     = 10;
    localparam int unsigned VSync      = 2;
    localparam int unsigned VBack      = 33;
    localparam int unsigned VTotal     = VVisible + VFront + VSync + VBack;

    localparam int unsigned HSyncStart = HVisible + HFront;
    localparam int unsigned HSyncEnd   = HSyncStart + HSync;
    localparam int unsigned VSyncStart = VVisible + VFront;
    localparam int unsigned VSyncEnd   = VSyncStart + VSync;

    localparam int unsigned BandHeight = 120;

    typedef enum logic [1:0] {
        AxActive = 2'd0,
        AxFront  = 2'd1,
        AxSync   = 2'd2,
        AxBack   = 2'd3
    } axis_state_e;

    // Band index by comparison against multiples of the band height; saturates at 3.
    function automatic logic [1:0] band_of(input logic [CoordW-1:0] row,
                                           input int unsigned height);
        int unsigned r;
        r = 32'(row);
        if (r >= 3 * height) begin
            return 2'd3;
        end else if (r >= 2 * height) begin
            return 2'd2;
        end else if (r >= height) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Output bundle of the VGA sequencer: pixel strobe, coordinates, syncs, video gate and band.
interface vga_timing_ctrl_if;
    import vga_pkg::*;

    logic              oPixelTick;
    logic [CoordW-1:0] oCol;
    logic [CoordW-1:0] oRow;
    logic              oHSync;
    logic              oVSync;
    logic              oVideoOn;
    logic [1:0]        oBand;
    logic              oFrameStart;
    axis_state_e       h_state;
    axis_state_e       v_state;

    modport master (
        output oPixelTick, oCol, oRow, oHSync, oVSync, oVideoOn, oBand, oFrameStart,
        output h_state, v_state
    );

    modport slave (
        input oPixelTick, oCol, oRow, oHSync, oVSync, oVideoOn, oBand, oFrameStart,
        input h_state, v_state
    );

endinterface

// File: rtl/vga_axis_fsm.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK sequencer, stepped by
// advance. Registered outputs are decoded from next-state so they track count exactly.
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int unsigned Visible = 640,
    parameter int unsigned Front   = 16,
    parameter int unsigned Sync    = 96,
    parameter int unsigned Back    = 48,
    parameter int unsigned Width   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [Width-1:0] count,
    output axis_state_e      state,
    output logic             sync_n,
    output logic             active,
    output logic             wrap
);

    localparam int unsigned Total = Visible + Front + Sync + Back;
    localparam logic [Width-1:0] LastCnt  = Width'(Total - 1);
    localparam logic [Width-1:0] FrontAt  = Width'(Visible);
    localparam logic [Width-1:0] SyncAt   = Width'(Visible + Front);
    localparam logic [Width-1:0] BackAt   = Width'(Visible + Front + Sync);

    logic [Width-1:0] count_q, count_d;
    axis_state_e      state_q, state_d;
    logic             sync_n_q;
    logic             active_q;

    always_comb begin
        // Any out-of-range count is treated as the last position and wraps on next advance.
        wrap    = advance && (count_q >= LastCnt);
        count_d = count_q;
        state_d = state_q;
        if (advance) begin
            count_d = wrap ? '0 : count_q + Width'(1);
            if (count_d == '0) begin
                state_d = AxActive;
            end else if (count_d == FrontAt) begin
                state_d = AxFront;
            end else if (count_d == SyncAt) begin
                state_d = AxSync;
            end else if (count_d == BackAt) begin
                state_d = AxBack;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            state_q  <= AxActive;
            sync_n_q <= 1'b1;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            state_q  <= state_d;
            sync_n_q <= (state_d != AxSync);
            active_q <= (state_d == AxActive);
        end
    end

    assign count  = count_q;
    assign state  = state_q;
    assign sync_n = sync_n_q;
    assign active = active_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: pixel-rate divider, horizontal and vertical axis sequencers,
// colour band index and frame-start strobe.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV     = ClkDiv,
    parameter int unsigned H_VISIBLE   = HVisible,
    parameter int unsigned H_FRONT     = HFront,
    parameter int unsigned H_SYNC      = HSync,
    parameter int unsigned H_BACK      = HBack,
    parameter int unsigned V_VISIBLE   = VVisible,
    parameter int unsigned V_FRONT     = VFront,
    parameter int unsigned V_SYNC      = VSync,
    parameter int unsigned V_BACK      = VBack,
    parameter int unsigned BAND_HEIGHT = BandHeight
) (
    input logic               Clock,
    input logic               Reset,
    vga_timing_ctrl_if.master vga
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0]   div_q, div_d;
    logic              tick;
    logic              pixel_tick_q;
    logic              frame_start_q;
    logic [1:0]        band_q;
    logic [CoordW-1:0] row_next;

    logic [CoordW-1:0] h_count, v_count;
    axis_state_e       h_state, v_state;
    logic              h_sync_n, v_sync_n;
    logic              h_active, v_active;
    logic              h_wrap, v_wrap;

    always_comb begin
        tick  = (div_q >= DivLast);
        div_d = tick ? '0 : div_q + DivW'(1);
    end

    vga_axis_fsm #(
        .Visible (H_VISIBLE),
        .Front   (H_FRONT),
        .Sync    (H_SYNC),
        .Back    (H_BACK),
        .Width   (CoordW)
    ) u_h_axis (
        .clk     (Clock),
        .rst     (Reset),
        .advance (tick),
        .count   (h_count),
        .state   (h_state),
        .sync_n  (h_sync_n),
        .active  (h_active),
        .wrap    (h_wrap)
    );

    vga_axis_fsm #(
        .Visible (V_VISIBLE),
        .Front   (V_FRONT),
        .Sync    (V_SYNC),
        .Back    (V_BACK),
        .Width   (CoordW)
    ) u_v_axis (
        .clk     (Clock),
        .rst     (Reset),
        .advance (h_wrap),
        .count   (v_count),
        .state   (v_state),
        .sync_n  (v_sync_n),
        .active  (v_active),
        .wrap    (v_wrap)
    );

    // Band is registered from the next row so it changes on the same edge as oRow.
    always_comb begin
        row_next = v_count;
        if (v_wrap) begin
            row_next = '0;
        end else if (h_wrap) begin
            row_next = v_count + CoordW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_q         <= '0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
            band_q        <= 2'd0;
        end else begin
            div_q         <= div_d;
            pixel_tick_q  <= tick;
            frame_start_q <= v_wrap;
            band_q        <= band_of(row_next, BAND_HEIGHT);
        end
    end

    assign vga.oPixelTick  = pixel_tick_q;
    assign vga.oCol        = h_count;
    assign vga.oRow        = v_count;
    assign vga.oHSync      = h_sync_n;
    assign vga.oVSync      = v_sync_n;
    assign vga.oVideoOn    = h_active & v_active;
    assign vga.oBand       = band_q;
    assign vga.oFrameStart = frame_start_q;
    assign vga.h_state     = h_state;
    assign vga.v_state     = v_state;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: full-size 640x480 instance for line timing plus a shrunken instance for frame, vsync
// and band boundaries, both driven by one clock/reset and checked from a vector table.
module tb_vga_timing_ctrl;
    import vga_pkg::*;

    logic Clock;
    logic Reset;

    vga_timing_ctrl_if vf();
    vga_timing_ctrl_if vsm();

    vga_timing_ctrl u_full (
        .Clock (Clock),
        .Reset (Reset),
        .vga   (vf.master)
    );

    // Small frame: H 8+2+3+2 = 15, V 12+2+2+3 = 19, bands of 3 rows.
    vga_timing_ctrl #(
        .CLK_DIV     (2),
        .H_VISIBLE   (8),
        .H_FRONT     (2),
        .H_SYNC      (3),
        .H_BACK      (2),
        .V_VISIBLE   (12),
        .V_FRONT     (2),
        .V_SYNC      (2),
        .V_BACK      (3),
        .BAND_HEIGHT (3)
    ) u_small (
        .Clock (Clock),
        .Reset (Reset),
        .vga   (vsm.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int sel;   // 0 = full, 1 = small
        int cyc;
        int col;
        int row;
        int hs;
        int vs;
        int von;
        int band;
        int fs;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   fs_full  = 0;
    int   fs_small = 0;

    always @(negedge Clock) begin
        if (!Reset) begin
            if (vf.oFrameStart)  fs_full++;
            if (vsm.oFrameStart) fs_small++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input int sel, input int c, input int col, input int row, input int hs,
                       input int vs, input int von, input int band, input int fs);
        vec_t v;
        v.sel = sel; v.cyc = c; v.col = col; v.row = row; v.hs = hs; v.vs = vs;
        v.von = von; v.band = band; v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic sample(input int sel, output int col, output int row, output int hs,
                          output int vs, output int von, output int band, output int fs,
                          output int pt, output int hst, output int vst);
        if (sel == 0) begin
            col = int'(vf.oCol); row = int'(vf.oRow); hs = int'(vf.oHSync);
            vs = int'(vf.oVSync); von = int'(vf.oVideoOn); band = int'(vf.oBand);
            fs = int'(vf.oFrameStart); pt = int'(vf.oPixelTick);
            hst = int'(vf.h_state); vst = int'(vf.v_state);
        end else begin
            col = int'(vsm.oCol); row = int'(vsm.oRow); hs = int'(vsm.oHSync);
            vs = int'(vsm.oVSync); von = int'(vsm.oVideoOn); band = int'(vsm.oBand);
            fs = int'(vsm.oFrameStart); pt = int'(vsm.oPixelTick);
            hst = int'(vsm.h_state); vst = int'(vsm.v_state);
        end
    endtask

    task automatic check_reset(input string tag);
        int col, row, hs, vs, von, band, fs, pt, hst, vst;
        for (int s = 0; s < 2; s++) begin
            sample(s, col, row, hs, vs, von, band, fs, pt, hst, vst);
            chk($sformatf("%s d%0d col", tag, s), col, 0);
            chk($sformatf("%s d%0d row", tag, s), row, 0);
            chk($sformatf("%s d%0d hsync", tag, s), hs, 1);
            chk($sformatf("%s d%0d vsync", tag, s), vs, 1);
            chk($sformatf("%s d%0d video_on", tag, s), von, 0);
            chk($sformatf("%s d%0d band", tag, s), band, 0);
            chk($sformatf("%s d%0d frame_start", tag, s), fs, 0);
            chk($sformatf("%s d%0d pixel_tick", tag, s), pt, 0);
            chk($sformatf("%s d%0d h_state", tag, s), hst, 0);
            chk($sformatf("%s d%0d v_state", tag, s), vst, 0);
        end
    endtask

    task automatic run_vectors(input int lo, input int hi, input string tag);
        int col, row, hs, vs, von, band, fs, pt, hst, vst;
        for (int i = lo; i <= hi; i++) begin
            if (cyc < vecs[i].cyc) begin
                while (cyc < vecs[i].cyc) begin
                    @(posedge Clock);
                    cyc++;
                end
                #1;
            end
            sample(vecs[i].sel, col, row, hs, vs, von, band, fs, pt, hst, vst);
            chk($sformatf("%s v%0d@%0d col", tag, i, cyc), col, vecs[i].col);
            chk($sformatf("%s v%0d@%0d row", tag, i, cyc), row, vecs[i].row);
            chk($sformatf("%s v%0d@%0d hsync", tag, i, cyc), hs, vecs[i].hs);
            chk($sformatf("%s v%0d@%0d vsync", tag, i, cyc), vs, vecs[i].vs);
            chk($sformatf("%s v%0d@%0d video_on", tag, i, cyc), von, vecs[i].von);
            chk($sformatf("%s v%0d@%0d band", tag, i, cyc), band, vecs[i].band);
            chk($sformatf("%s v%0d@%0d frame_start", tag, i, cyc), fs, vecs[i].fs);
            chk($sformatf("%s v%0d@%0d pixel_tick", tag, i, cyc), pt, (cyc % 2 == 0) ? 1 : 0);
        end
    endtask

    initial begin
        int rows[8];
        int bands[8];

        //  sel  cyc   col  row hs vs von band fs
        add(0,    1,    0,   0, 1, 1, 1, 0, 0);
        add(1,    1,    0,   0, 1, 1, 1, 0, 0);
        add(0,    2,    1,   0, 1, 1, 1, 0, 0);
        add(1,    2,    1,   0, 1, 1, 1, 0, 0);
        add(1,   19,    9,   0, 1, 1, 0, 0, 0);
        add(1,   20,   10,   0, 0, 1, 0, 0, 0);
        add(1,   26,   13,   0, 1, 1, 0, 0, 0);
        add(1,   30,    0,   1, 1, 1, 1, 0, 0);
        add(1,   60,    0,   2, 1, 1, 1, 0, 0);
        add(1,   90,    0,   3, 1, 1, 1, 1, 0);
        add(1,  150,    0,   5, 1, 1, 1, 1, 0);
        add(1,  180,    0,   6, 1, 1, 1, 2, 0);
        add(1,  240,    0,   8, 1, 1, 1, 2, 0);
        add(1,  270,    0,   9, 1, 1, 1, 3, 0);
        add(1,  360,    0,  12, 1, 1, 0, 3, 0);
        add(1,  419,   14,  13, 1, 1, 0, 3, 0);
        add(1,  420,    0,  14, 1, 0, 0, 3, 0);
        add(1,  440,   10,  14, 0, 0, 0, 3, 0);
        add(1,  479,   14,  15, 1, 0, 0, 3, 0);
        add(1,  480,    0,  16, 1, 1, 0, 3, 0);
        add(1,  569,   14,  18, 1, 1, 0, 3, 0);
        add(1,  570,    0,   0, 1, 1, 1, 0, 1);
        add(1,  571,    0,   0, 1, 1, 1, 0, 0);
        add(1, 1139,   14,  18, 1, 1, 0, 3, 0);
        add(1, 1140,    0,   0, 1, 1, 1, 0, 1);
        add(0, 1279,  639,   0, 1, 1, 1, 0, 0);
        add(0, 1280,  640,   0, 1, 1, 0, 0, 0);
        add(0, 1311,  655,   0, 1, 1, 0, 0, 0);
        add(0, 1312,  656,   0, 0, 1, 0, 0, 0);
        add(0, 1503,  751,   0, 0, 1, 0, 0, 0);
        add(0, 1504,  752,   0, 1, 1, 0, 0, 0);
        add(0, 1599,  799,   0, 1, 1, 0, 0, 0);
        add(0, 1600,    0,   1, 1, 1, 1, 0, 0);
        add(0, 2912,  656,   1, 0, 1, 0, 0, 0);
        add(0, 3104,  752,   1, 1, 1, 0, 0, 0);
        add(0, 3281,   40,   2, 1, 1, 1, 0, 0);
        add(1, 3281,    5,  14, 1, 0, 0, 3, 0);

        // Band helper at the real 120-row height.
        rows  = '{119, 120, 239, 240, 359, 360, 479, 524};
        bands = '{0,   1,   1,   2,   2,   3,   3,   3};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("band_of row %0d", rows[i]), int'(band_of(10'(rows[i]), BandHeight)),
                bands[i]);
        end

        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check_reset("in_reset");
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        cyc = 0;

        run_vectors(0, vecs.size() - 1, "run");
        chk("small frame_start count", fs_small, 5);
        chk("full frame_start count", fs_full, 0);

        // Asynchronous reset mid-frame, away from any clock edge.
        #3;
        Reset = 1'b1;
        #1;
        check_reset("async_reset");
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        cyc = 0;
        run_vectors(0, 3, "rerun");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
